// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode and FSM state encodings for the sequential ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SRL = 3'b101,
        OP_SLL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } alu_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
// Module      : alu_comb
// Description : Single-cycle ALU ops (ADD, SUB, AND, OR, XOR) with carry/borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] rslt,
    output logic             co
);

    logic [WIDTH:0] w_ext_a;
    logic [WIDTH:0] w_ext_b;
    logic [WIDTH:0] w_ext_c;
    logic [WIDTH:0] w_res;

    assign w_ext_a = {1'b0, a};
    assign w_ext_b = {1'b0, b};
    assign w_ext_c = {{WIDTH{1'b0}}, ci};

    // Bit WIDTH of the extended subtraction is the borrow out.
    always_comb begin
        w_res = '0;
        case (op)
            OP_ADD:  w_res = w_ext_a + w_ext_b + w_ext_c;
            OP_SUB:  w_res = w_ext_a - w_ext_b - w_ext_c;
            OP_AND:  w_res = {1'b0, a & b};
            OP_OR:   w_res = {1'b0, a | b};
            OP_XOR:  w_res = {1'b0, a ^ b};
            default: w_res = '0;
        endcase
    end

    assign rslt = w_res[WIDTH-1:0];
    assign co   = w_res[WIDTH];

endmodule : alu_comb
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered ALU with valid/ready handshake, iterative shifts
//               and shift-add multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_cmd,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             sc_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rslt,
    output logic             sc_o,
    output logic             zero,
    output logic             pari
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    alu_state_e             r_state;
    alu_state_e             w_state_nxt;
    logic [WIDTH-1:0]       r_rslt;
    logic                   r_sc;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_left;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;

    alu_op_e                w_op;
    logic                   w_accept;
    logic [SHAMT_W-1:0]     w_shamt;
    logic [WIDTH-1:0]       w_comb_rslt;
    logic                   w_comb_co;
    logic [2*WIDTH-1:0]     w_acc_nxt;
    logic                   w_last;

    assign w_op      = alu_op_e'(alu_cmd);
    assign w_accept  = in_valid && (r_state == ST_IDLE);
    assign w_shamt   = inB[SHAMT_W-1:0];
    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_last    = (r_cnt == c_CNT_W'(1));

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .op   (w_op),
        .a    (inA),
        .b    (inB),
        .ci   (sc_i),
        .rslt (w_comb_rslt),
        .co   (w_comb_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_SRL, OP_SLL: w_state_nxt = (w_shamt == '0) ? ST_DONE : ST_SHIFT;
                        OP_MUL:         w_state_nxt = ST_MUL;
                        default:        w_state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
            ST_MUL:   if (w_last) w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rslt   <= '0;
            r_sc     <= 1'b0;
            r_cnt    <= '0;
            r_left   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_SRL, OP_SLL: begin
                                r_rslt <= inA;
                                r_sc   <= 1'b0;
                                r_cnt  <= c_CNT_W'(w_shamt);
                                r_left <= (w_op == OP_SLL);
                            end
                            OP_MUL: begin
                                r_acc    <= '0;
                                r_mcand  <= {{WIDTH{1'b0}}, inA};
                                r_mplier <= inB;
                                r_cnt    <= c_CNT_W'(WIDTH);
                            end
                            default: begin
                                r_rslt <= w_comb_rslt;
                                r_sc   <= w_comb_co;
                            end
                        endcase
                    end
                end
                ST_SHIFT: begin
                    // The working value lives in r_rslt; sc_o tracks the bit just shifted out.
                    if (r_left) begin
                        {r_sc, r_rslt} <= {r_rslt, 1'b0};
                    end else begin
                        {r_rslt, r_sc} <= {1'b0, r_rslt};
                    end
                    r_cnt <= r_cnt - 1'b1;
                end
                ST_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_rslt <= w_acc_nxt[WIDTH-1:0];
                        r_sc   <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign rslt      = r_rslt;
    assign sc_o      = r_sc;
    assign zero      = ~|r_rslt;
    assign pari      = ^r_rslt;

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] alu_cmd;
    logic [7:0] inA;
    logic [7:0] inB;
    logic       sc_i;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] rslt;
    logic       sc_o;
    logic       zero;
    logic       pari;

    int total = 0;
    int bad   = 0;

    alu_seq #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_cmd   (alu_cmd),
        .inA       (inA),
        .inB       (inB),
        .sc_i      (sc_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rslt      (rslt),
        .sc_o      (sc_o),
        .zero      (zero),
        .pari      (pari)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble operands after accept, measure latency, check, drain.
    task automatic run_op(input string tag, input logic [2:0] cmd, input logic [7:0] a,
                          input logic [7:0] b, input logic ci, input int exp_lat,
                          input logic [7:0] exp_r, input logic exp_sc);
        int lat;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        alu_cmd  = cmd;
        inA      = a;
        inB      = b;
        sc_i     = ci;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        inA      = ~a;
        inB      = ~b;
        sc_i     = ~ci;
        alu_cmd  = ~cmd;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rslt"}, 32'(rslt), 32'(exp_r));
        chk({tag, "_sc_o"}, 32'(sc_o), 32'(exp_sc));
        chk({tag, "_zero"}, 32'(zero), 32'(exp_r == 8'h00));
        chk({tag, "_pari"}, 32'(pari), 32'(^exp_r));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_cmd   = 3'b000;
        inA       = 8'h00;
        inB       = 8'h00;
        sc_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rslt", 32'(rslt), 32'd0);
        chk("rst_sc_o", 32'(sc_o), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_pari", 32'(pari), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // out_ready while idle must be ignored
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_out_ready", 32'(out_valid), 32'd0);

        run_op("add_ff_01", 3'b000, 8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1);
        run_op("sub_03_05", 3'b001, 8'h03, 8'h05, 1'b0, 1, 8'hFE, 1'b1);
        run_op("add_ci",    3'b000, 8'h10, 8'h20, 1'b1, 1, 8'h31, 1'b0);
        run_op("sub_bi",    3'b001, 8'h05, 8'h03, 1'b1, 1, 8'h01, 1'b0);
        run_op("and",       3'b010, 8'hA5, 8'h3C, 1'b1, 1, 8'h24, 1'b0);
        run_op("or",        3'b011, 8'hA5, 8'h3C, 1'b1, 1, 8'hBD, 1'b0);
        run_op("xor",       3'b100, 8'hA5, 8'h3C, 1'b1, 1, 8'h99, 1'b0);
        run_op("srl_3",     3'b101, 8'b1011_0001, 8'd3, 1'b0, 4, 8'b0001_0110, 1'b0);
        run_op("sll_3",     3'b110, 8'b1011_0001, 8'd3, 1'b0, 4, 8'b1000_1000, 1'b1);
        run_op("srl_0",     3'b101, 8'hB1, 8'h08, 1'b1, 1, 8'hB1, 1'b0);
        run_op("sll_7",     3'b110, 8'h03, 8'd7, 1'b0, 8, 8'h80, 1'b1);
        run_op("mul_13_11", 3'b111, 8'd13, 8'd11, 1'b0, 9, 8'd143, 1'b0);
        run_op("mul_20_20", 3'b111, 8'd20, 8'd20, 1'b0, 9, 8'h90, 1'b1);

        // Reset during MUL at iteration 3
        alu_cmd  = 3'b111;
        inA      = 8'hFF;
        inB      = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_rslt", 32'(rslt), 32'd0);
        chk("midrst_zero", 32'(zero), 32'd1);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op("post_rst_mul", 3'b111, 8'd7, 8'd6, 1'b0, 9, 8'd42, 1'b0);

        // Backpressure: result held, new request ignored until drained
        alu_cmd  = 3'b000;
        inA      = 8'h40;
        inB      = 8'h02;
        sc_i     = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        alu_cmd = 3'b100;
        inA     = 8'h0F;
        inB     = 8'hF0;
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_rslt0", 32'(rslt), 32'h42);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_rslt", 32'(rslt), 32'h42);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_rslt", 32'(rslt), 32'hFF);
        chk("bp_next_sc_o", 32'(sc_o), 32'd0);
        chk("bp_next_pari", 32'(pari), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_final_in_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_seq
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath ALU: WIDTH-bit operands, 3-bit command, carry/borrow in, flags out.
- Adds a valid/ready handshake on both sides and multi-cycle iterative ops: variable-distance shifts and shift-add multiply.
- Sits between the register file read stage and writeback; the controller holds the issue stage while in_ready is low.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- SHAMT_W, $clog2(WIDTH), width of shift amount taken from inB[SHAMT_W-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  command/operands present.
- in_ready  output  1  block can accept; high only in IDLE.
- alu_cmd  input  3  operation code (see Behaviour).
- inA  input  WIDTH  operand A.
- inB  input  WIDTH  operand B / shift amount.
- sc_i  input  1  carry in (ADD) / borrow in (SUB); ignored otherwise.
- out_valid  output  1  result registers hold a completed op.
- out_ready  input  1  consumer takes result.
- rslt  output  WIDTH  registered result.
- sc_o  output  1  carry/borrow/last-bit-out/overflow (per op).
- zero  output  1  rslt == 0.
- pari  output  1  ^rslt.

Behaviour:
- Clock clk; reset asynchronous, active-low, on rst_n.
- Reset (async, any state, including mid-op): state=IDLE, rslt=0, sc_o=0, out_valid=0, in_ready=1, zero=1, pari=0, iteration counter=0; in-flight op discarded.
- Accept = in_valid & in_ready (rising edge). inA, inB, sc_i, alu_cmd captured only at accept; later changes ignored.
- Opcodes: 000 ADD {sc_o,rslt}=inA+inB+sc_i; 001 SUB {sc_o,rslt}=inA-inB-sc_i, sc_o=1 on borrow; 010 AND; 011 OR; 100 XOR (logic ops sc_o=0); 101 SRL by n=inB[SHAMT_W-1:0]; 110 SLL by n; 111 MUL low WIDTH bits of inA*inB.
- States: IDLE, SHIFT, MUL, DONE.
- IDLE: on accept of ADD/SUB/logic -> result registered, go DONE (out_valid next cycle, latency 1). SRL/SLL with n=0 -> rslt=inA, sc_o=0, DONE. SRL/SLL with n>0 -> load working reg=inA, count=n, go SHIFT. MUL -> load multiplicand/multiplier, product acc=0, count=WIDTH, go MUL.
- SHIFT: one bit per cycle, zero filled; sc_o = bit shifted out this cycle; count-1; at count==1 move to DONE with final value. Total latency n+1 cycles from accept to out_valid.
- MUL: per cycle, if multiplier LSB then acc+=multiplicand (2*WIDTH acc); multiplicand<<1, multiplier>>1; after WIDTH iterations -> DONE. rslt=acc[WIDTH-1:0], sc_o=|acc[2*WIDTH-1:WIDTH] (overflow). Latency WIDTH+1.
- DONE: out_valid=1; rslt/sc_o/zero/pari stable while out_valid & !out_ready. On out_ready -> IDLE next cycle; in_ready rises that cycle. No accept while in DONE (no same-cycle drain+accept).
- zero, pari derived combinationally from registered rslt; intermediate values during SHIFT/MUL may be visible on rslt but are only valid when out_valid=1.
- out_ready while out_valid=0 ignored. in_valid while in_ready=0 ignored (no queueing).
- Undefined opcodes: none; all 8 encodings defined.

Decomposition:
- Package alu_pkg: enum alu_op_e {ADD,SUB,AND,OR,XOR,SRL,SLL,MUL} on 3 bits; state enum {IDLE,SHIFT,MUL,DONE}.
- One sub-module natural: alu_comb (combinational single-cycle ops ADD..XOR, parametrised WIDTH, returns {sc_o,rslt}); FSM, shifter and multiplier iteration live in alu_seq.

Test Plan:
- Reset during MUL (assert rst_n=0 at iteration 3) -> immediately out_valid=0, rslt=0, zero=1, in_ready=1; next op runs correctly.
- ADD inA=8'hFF, inB=8'h01, sc_i=0 -> one cycle later out_valid=1, rslt=8'h00, sc_o=1, zero=1, pari=0; SUB 8'h03-8'h05 sc_i=0 -> rslt=8'hFE, sc_o=1, pari=1.
- SRL inA=8'b1011_0001, inB=3 -> out_valid 4 cycles after accept, rslt=8'b0001_0110, sc_o=0; SLL same operands -> rslt=8'b1000_1000, sc_o=1; n=0 -> rslt=inA in 1 cycle.
- MUL 8'd13*8'd11 -> after 9 cycles rslt=8'd143, sc_o=0; MUL 8'd20*8'd20 -> rslt=8'h90, sc_o=1.
- Backpressure: hold out_ready=0 for 5 cycles after DONE with in_valid=1 and new operands -> rslt stable, in_ready=0, new op not accepted; release -> IDLE, new op accepted next cycle.
- Operand change after accept: alter inA/inB during SHIFT -> result matches captured values.
